// File: rtl/add_pipe_acc_pkg.sv
// add_pkg: shared types and width helpers for the add_pipe_acc block.
//   mode_e          - per-transaction operation code carried with each operand pair
//   pair_sum_width  - width needed to hold a+b of two w-bit operands without losing the carry
//   acc_width_ok    - true when an accumulator of width aw can hold a full pair sum
package add_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_ACC  = 2'd1,
    MODE_LOAD = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int unsigned MODE_W = 2;

  function automatic int unsigned pair_sum_width(input int unsigned w);
    return w + 32'd1;
  endfunction

  function automatic bit acc_width_ok(input int unsigned w, input int unsigned aw);
    return aw >= pair_sum_width(w);
  endfunction

endpackage

// File: rtl/add_pipe_acc_if.sv
// add_pipe_acc_if: operand input and result output handshakes of add_pipe_acc.
//   in_valid/in_ready/in_a/in_b/in_mode   - operand transfer (producer -> block)
//   out_valid/out_ready/out_sum/out_ovf   - result transfer (block -> consumer)
//   modport master : producer/consumer side (testbench or upstream logic)
//   modport slave  : the add_pipe_acc block itself
interface add_pipe_acc_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
);
  import add_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [MODE_W-1:0]    in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/add_pipe_acc_pipe_stage.sv
// pipe_stage: generic valid/ready register slice.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - upstream handshake; in_data captured on transfer
//   out_valid/out_ready - downstream handshake; out_data is the held payload
// The slice accepts when empty or when its current content leaves this cycle,
// so in_ready depends only on the stored valid and out_ready, never on in_valid.
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid;
  logic [DW-1:0] data;

  assign in_ready  = !valid || out_ready;
  assign out_valid = valid;
  assign out_data  = data;

  // Payload register: load on transfer, otherwise empty out once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (in_valid && in_ready) begin
      valid <= 1'b1;
      data  <= in_data;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/add_pipe_acc.sv
// add_pipe_acc: two-stage pipelined adder / accumulator.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - add_pipe_acc_if slave: operands + mode in, result + overflow out
// Stage 1 is a plain register slice for {mode, b, a}. Stage 2 computes the
// result, owns the accumulator and drives out_*. One op enters stage 2 per
// cycle, so back-to-back ACC ops always see the previous op's accumulator.
module add_pipe_acc
  import add_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int SAT       = 0
) (
  input logic          clk,
  input logic          rst_n,
  add_pipe_acc_if.slave bus
);

  localparam int PW = 2 * WIDTH + MODE_W;

  generate
    if (!acc_width_ok(WIDTH, ACC_WIDTH)) begin : g_width_check
      $error("add_pipe_acc: ACC_WIDTH must be at least WIDTH+1");
    end
  endgenerate

  // Stage 1
  logic          s1_valid;
  logic [PW-1:0] s1_data;
  logic          s2_ready;

  pipe_stage #(.DW(PW)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({bus.in_mode, bus.in_b, bus.in_a}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  mode_e            s1_mode;

  assign s1_a    = s1_data[WIDTH-1:0];
  assign s1_b    = s1_data[2*WIDTH-1:WIDTH];
  assign s1_mode = mode_e'(s1_data[PW-1:2*WIDTH]);

  // Stage 2
  logic                 s2_valid;
  logic [ACC_WIDTH-1:0] s2_sum;
  logic                 s2_ovf;
  logic [ACC_WIDTH-1:0] acc;
  logic                 s2_load;

  logic [WIDTH:0]       pair_sum;
  logic [ACC_WIDTH:0]   acc_raw;
  logic [ACC_WIDTH-1:0] next_sum;
  logic [ACC_WIDTH-1:0] next_acc;
  logic                 next_ovf;

  // Stage 2 frozen only while it holds a result the consumer is refusing.
  assign s2_ready = !s2_valid || bus.out_ready;
  assign s2_load  = s1_valid && s2_ready;

  // Carry of a+b kept; the accumulate sum gets one extra bit to expose overflow.
  assign pair_sum = {1'b0, s1_a} + {1'b0, s1_b};
  assign acc_raw  = {1'b0, acc} + (ACC_WIDTH+1)'(pair_sum);

  // Result, accumulator update and overflow for the op in stage 1.
  always_comb begin
    next_sum = ACC_WIDTH'(pair_sum);
    next_acc = acc;
    next_ovf = 1'b0;
    case (s1_mode)
      MODE_LOAD: begin
        next_acc = ACC_WIDTH'(pair_sum);
      end
      MODE_ACC: begin
        if (acc_raw[ACC_WIDTH]) begin
          next_ovf = 1'b1;
          if (SAT != 0) begin
            next_sum = '1;
          end else begin
            next_sum = acc_raw[ACC_WIDTH-1:0];
          end
        end else begin
          next_sum = acc_raw[ACC_WIDTH-1:0];
        end
        next_acc = next_sum;
      end
      MODE_ADD, MODE_RSVD: begin
        next_sum = ACC_WIDTH'(pair_sum);
      end
      default: begin
        next_sum = ACC_WIDTH'(pair_sum);
      end
    endcase
  end

  // Stage 2 registers: outputs and accumulator change only when stage 2 reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_ovf   <= 1'b0;
      acc      <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_sum   <= next_sum;
      s2_ovf   <= next_ovf;
      acc      <= next_acc;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_sum   = s2_sum;
  assign bus.out_ovf   = s2_ovf;

endmodule

// File: tb/tb_add_pipe_acc.sv
// tb_add_pipe_acc: drives identical stimulus into a wrapping (SAT=0) and a
// saturating (SAT=1) instance and checks both against hand-computed values.
module tb_add_pipe_acc;
  import add_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] in_mode;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  add_pipe_acc_if #(.WIDTH(4), .ACC_WIDTH(8)) bus0 ();
  add_pipe_acc_if #(.WIDTH(4), .ACC_WIDTH(8)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_a      = in_a;
  assign bus0.in_b      = in_b;
  assign bus0.in_mode   = in_mode;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus1.in_mode   = in_mode;
  assign bus1.out_ready = out_ready;

  add_pipe_acc #(.WIDTH(4), .ACC_WIDTH(8), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  add_pipe_acc #(.WIDTH(4), .ACC_WIDTH(8), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] sum0;
    logic       ovf0;
    logic [7:0] sum1;
    logic       ovf1;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] m, input int a, input int b,
                         input int s0, input int o0, input int s1, input int o1);
    vec_t v;
    v.mode = m;
    v.a    = a[3:0];
    v.b    = b[3:0];
    v.sum0 = s0[7:0];
    v.ovf0 = o0[0];
    v.sum1 = s1[7:0];
    v.ovf1 = o1[0];
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input int a, input int b);
    in_valid = v;
    in_mode  = m;
    in_a     = a[3:0];
    in_b     = b[3:0];
  endtask

  initial begin
    int   idx;
    logic took;
    int   got[$];
    int   n_out;
    int   r0;
    int   r1;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, MODE_ADD, 0, 0);

    // Reset state
    #12;
    check("rst_in_ready0", bus0.in_ready, 1);
    check("rst_in_ready1", bus1.in_ready, 1);
    check("rst_out_valid0", bus0.out_valid, 0);
    check("rst_out_valid1", bus1.out_valid, 0);
    check("rst_out_sum0", bus0.out_sum, 0);
    check("rst_out_ovf0", bus0.out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streamed vector table: expected {sum,ovf} for SAT=0 then SAT=1
    add_vec(MODE_ADD,  1,  5,   6, 0,   6, 0);
    add_vec(MODE_ADD, 15, 15,  30, 0,  30, 0);
    add_vec(MODE_LOAD, 0,  0,   0, 0,   0, 0);
    add_vec(MODE_ACC, 15, 15,  30, 0,  30, 0);
    add_vec(MODE_ACC, 15, 15,  60, 0,  60, 0);
    add_vec(MODE_ACC, 15, 15,  90, 0,  90, 0);
    add_vec(MODE_RSVD, 3,  4,   7, 0,   7, 0);
    add_vec(MODE_ACC,  0,  0,  90, 0,  90, 0);
    add_vec(MODE_LOAD,15, 15,  30, 0,  30, 0);
    for (int i = 2; i <= 8; i++) add_vec(MODE_ACC, 15, 15, 30 * i, 0, 30 * i, 0);
    add_vec(MODE_ACC, 15, 15,  14, 1, 255, 1);
    add_vec(MODE_ACC,  1,  0,  15, 0, 255, 1);
    add_vec(MODE_ACC,  0,  0,  15, 0, 255, 0);
    add_vec(MODE_ADD,  9,  7,  16, 0,  16, 0);

    for (int k = 0; k < vecs.size() + 2; k++) begin
      @(posedge clk); #1;
      if (k < vecs.size()) drive(1'b1, vecs[k].mode, vecs[k].a, vecs[k].b);
      else                 drive(1'b0, MODE_ADD, 0, 0);
      @(negedge clk);
      check($sformatf("vec_in_ready[%0d]", k), bus0.in_ready, 1);
      if (k >= 2) begin
        check($sformatf("vec_valid0[%0d]", k - 2), bus0.out_valid, 1);
        check($sformatf("vec_valid1[%0d]", k - 2), bus1.out_valid, 1);
        check($sformatf("vec_sum0[%0d]", k - 2), bus0.out_sum, vecs[k-2].sum0);
        check($sformatf("vec_ovf0[%0d]", k - 2), bus0.out_ovf, vecs[k-2].ovf0);
        check($sformatf("vec_sum1[%0d]", k - 2), bus1.out_sum, vecs[k-2].sum1);
        check($sformatf("vec_ovf1[%0d]", k - 2), bus1.out_ovf, vecs[k-2].ovf1);
      end else begin
        check($sformatf("vec_latency_valid[%0d]", k), bus0.out_valid, 0);
      end
    end

    // Backpressure: consumer stalls for 6 cycles while four ADDs are offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(idx < 4, MODE_ADD, idx + 1, idx + 1);
      #1;
      took = in_valid && bus0.in_ready;
      if (c >= 2) begin
        check($sformatf("bp_in_ready[%0d]", c), bus0.in_ready, 0);
        check($sformatf("bp_out_valid[%0d]", c), bus0.out_valid, 1);
        check($sformatf("bp_out_sum_held[%0d]", c), bus0.out_sum, 2);
      end
      @(posedge clk); #1;
      if (took) idx++;
    end
    check("bp_accepted_while_stalled", idx, 2);

    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(idx < 4, MODE_ADD, idx + 1, idx + 1);
      #1;
      took = in_valid && bus0.in_ready;
      if (bus0.out_valid) got.push_back(int'(bus0.out_sum));
      @(posedge clk); #1;
      if (took) idx++;
    end
    check("bp_out_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_order[%0d]", i), (i < got.size()) ? got[i] : -1, 2 * (i + 1));

    // Reset with both stages full
    drive(1'b0, MODE_ADD, 0, 0);
    out_ready = 1'b0;
    drive(1'b1, MODE_ACC, 1, 1);
    @(posedge clk); #1;
    drive(1'b1, MODE_ACC, 2, 2);
    @(posedge clk); #1;
    drive(1'b0, MODE_ADD, 0, 0);
    check("mid_full_out_valid", bus0.out_valid, 1);
    check("mid_full_in_ready", bus0.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid0", bus0.out_valid, 0);
    check("mid_rst_out_valid1", bus1.out_valid, 0);
    check("mid_rst_acc0", dut0.acc, 0);
    check("mid_rst_acc1", dut1.acc, 0);
    check("mid_rst_in_ready", bus0.in_ready, 1);
    check("mid_rst_out_sum", bus0.out_sum, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, MODE_ACC, 2, 3);
    @(posedge clk); #1;
    drive(1'b0, MODE_ADD, 0, 0);
    n_out = 0;
    r0 = -1;
    r1 = -1;
    for (int c = 0; c < 6; c++) begin
      if (bus0.out_valid) begin
        n_out++;
        r0 = int'(bus0.out_sum);
        r1 = int'(bus1.out_sum);
      end
      @(posedge clk); #1;
    end
    check("post_rst_out_count", n_out, 1);
    check("post_rst_sum0", r0, 5);
    check("post_rst_sum1", r1, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
